// File: rtl/stage_probe_tracer_if.sv
// Record stream from the probe tracer to its consumer.
// Master drives the head record; slave returns ready.
interface stage_probe_tracer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int TS_W   = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              rec_valid;
  logic              rec_ready;
  logic [CH_W-1:0]   rec_ch;
  logic [DATA_W-1:0] rec_data;
  logic [TS_W-1:0]   rec_ts;

  modport master (
    output rec_valid, rec_ch, rec_data, rec_ts,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_ch, rec_data, rec_ts,
    output rec_ready
  );
endinterface

// File: rtl/stage_probe_tracer.sv
// Time-stamps valid-qualified probe channels into a show-ahead record FIFO.
// Define PROBE_TRACE_FILTER_EN to suppress repeated identical channel values.
module stage_probe_tracer #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 16,
  parameter  int TS_W   = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int LV_W   = AW + 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     i_en,
  input  logic                     i_clear,
  input  logic [NUM_CH-1:0]        i_ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  stage_probe_tracer_if.master     rec,
  output logic [LV_W-1:0]          o_level,
  output logic [15:0]              o_drop_cnt
);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } rec_t;

  logic [TS_W-1:0]   ts_q;
  logic [NUM_CH-1:0] sk_vld_q;
  logic [DATA_W-1:0] sk_data_q [NUM_CH];
  logic [TS_W-1:0]   sk_ts_q   [NUM_CH];
  logic [CH_W-1:0]   last_q;
  rec_t              mem_q     [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LV_W-1:0]   cnt_q;
  logic [15:0]       drop_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  rec_t              gnt_rec;
  rec_t              head;
  logic [NUM_CH-1:0] smp;
  logic [NUM_CH-1:0] drain;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drop;
  logic [4:0]        ndrop;
  logic [16:0]       drop_sum;

  assign full  = (cnt_q == LV_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = gnt_vld;
  assign pop   = !empty && rec.rec_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

`ifdef PROBE_TRACE_FILTER_EN
  logic [DATA_W-1:0] last_d_q [NUM_CH];

  always_comb begin
    smp = '0;
    for (int c = 0; c < NUM_CH; c++)
      smp[c] = i_en && i_ch_valid[c] &&
               (i_ch_data[c*DATA_W +: DATA_W] != last_d_q[c]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < NUM_CH; c++) last_d_q[c] <= '0;
    end else if (i_clear) begin
      for (int c = 0; c < NUM_CH; c++) last_d_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (load[c]) last_d_q[c] <= i_ch_data[c*DATA_W +: DATA_W];
    end
  end
`else
  always_comb begin
    smp = '0;
    for (int c = 0; c < NUM_CH; c++)
      smp[c] = i_en && i_ch_valid[c];
  end
`endif

  // Round-robin: search begins just after the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NUM_CH;
      if (!full && !gnt_vld && sk_vld_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    drain   = '0;
    load    = '0;
    drop    = '0;
    ndrop   = '0;
    gnt_rec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drain[c] = gnt_vld && (gnt_idx == CH_W'(c));
      load[c]  = smp[c] && (!sk_vld_q[c] || drain[c]);
      drop[c]  = smp[c] && sk_vld_q[c] && !drain[c];
      ndrop    = ndrop + 5'(drop[c]);
      if (drain[c]) begin
        gnt_rec.ch   = CH_W'(c);
        gnt_rec.data = sk_data_q[c];
        gnt_rec.ts   = sk_ts_q[c];
      end
    end
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sk_vld_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sk_data_q[c] <= '0;
        sk_ts_q[c]   <= '0;
      end
    end else if (i_clear) begin
      sk_vld_q <= '0;
    end else begin
      sk_vld_q <= (sk_vld_q & ~drain) | load;
      for (int c = 0; c < NUM_CH; c++) begin
        if (load[c]) begin
          sk_data_q[c] <= i_ch_data[c*DATA_W +: DATA_W];
          sk_ts_q[c]   <= ts_q;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)               drop_q <= '0;
    else if (i_clear)         drop_q <= '0;
    else if (drop_sum[16])    drop_q <= 16'hFFFF;
    else                      drop_q <= drop_sum[15:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= gnt_rec;
        wr_q        <= wr_q + AW'(1);
        last_q      <= gnt_idx;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + LV_W'(1);
        pop && !push: cnt_q <= cnt_q - LV_W'(1);
        default:      cnt_q <= cnt_q;
      endcase
    end
  end

  assign head          = empty ? '0 : mem_q[rd_q];
  assign rec.rec_valid = !empty;
  assign rec.rec_ch    = head.ch;
  assign rec.rec_data  = head.data;
  assign rec.rec_ts    = head.ts;
  assign o_level       = cnt_q;
  assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_stage_probe_tracer.sv
// Directed bench for stage_probe_tracer (NUM_CH=4, DATA_W=32, DEPTH=4).
// Follows PROBE_TRACE_FILTER_EN to pick filter-test expectations.
`timescale 1ns/1ps
module tb_stage_probe_tracer;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 32;

  logic                     CLK = 1'b0;
  logic                     RST_N = 1'b0;
  logic                     i_en;
  logic                     i_clear;
  logic [NUM_CH-1:0]        i_ch_valid;
  logic [NUM_CH*DATA_W-1:0] i_ch_data;
  logic [2:0]               o_level;
  logic [15:0]              o_drop_cnt;
  logic [TS_W-1:0]          mts;
  int checks = 0;
  int errors = 0;

  stage_probe_tracer_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)
  ) rec ();

  stage_probe_tracer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .i_en(i_en),
    .i_clear(i_clear),
    .i_ch_valid(i_ch_valid),
    .i_ch_data(i_ch_data),
    .rec(rec),
    .o_level(o_level),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp: counts edges since reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mts <= '0;
    else        mts <= mts + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    i_ch_valid = v;
    i_ch_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle();
    i_ch_valid = '0;
    i_ch_data  = '0;
  endtask

  logic [TS_W-1:0] t0;
  logic [31:0]     fexp [4];
  int              nf;
  logic [31:0]     fval [4];

  initial begin
    i_en          = 1'b1;
    i_clear       = 1'b0;
    rec.rec_ready = 1'b0;
    idle();

    // reset state
    #12;
    chk("rst_valid", 64'(rec.rec_valid), 64'd0);
    chk("rst_ch",    64'(rec.rec_ch),    64'd0);
    chk("rst_data",  64'(rec.rec_data),  64'd0);
    chk("rst_ts",    64'(rec.rec_ts),    64'd0);
    chk("rst_level", 64'(o_level),       64'd0);
    chk("rst_drop",  64'(o_drop_cnt),    64'd0);
    #10 RST_N = 1'b1;

    // single sample on ch2 at ts 10
    for (int k = 0; k < 40 && mts != 32'd10; k++) tick();
    drive(4'b0100, 32'h0, 32'h0, 32'h8000_0000, 32'h0);
    tick();
    idle();
    chk("single_n1_valid", 64'(rec.rec_valid), 64'd0);
    tick();
    chk("single_valid", 64'(rec.rec_valid), 64'd1);
    chk("single_ch",    64'(rec.rec_ch),    64'd2);
    chk("single_data",  64'(rec.rec_data),  64'h8000_0000);
    chk("single_ts",    64'(rec.rec_ts),    64'd10);
    chk("single_level", 64'(o_level),       64'd1);
    rec.rec_ready = 1'b1;
    tick();
    rec.rec_ready = 1'b0;
    chk("single_pop_valid", 64'(rec.rec_valid), 64'd0);
    chk("single_pop_level", 64'(o_level),       64'd0);

    // ch3 sample moves last grant to ch3
    drive(4'b1000, 32'h0, 32'h0, 32'h0, 32'h33);
    tick();
    idle();
    tick();
    chk("ch3_ch",   64'(rec.rec_ch),   64'd3);
    chk("ch3_data", 64'(rec.rec_data), 64'h33);
    rec.rec_ready = 1'b1;
    tick();
    rec.rec_ready = 1'b0;

    // capture disabled
    i_en = 1'b0;
    drive(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    idle();
    i_en = 1'b1;
    tick();
    tick();
    chk("en0_valid", 64'(rec.rec_valid), 64'd0);
    chk("en0_drop",  64'(o_drop_cnt),    64'd0);

    // round-robin, all channels in one cycle
    t0 = mts;
    drive(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    chk("rr_level", 64'(o_level),    64'd4);
    chk("rr_drop",  64'(o_drop_cnt), 64'd0);
    rec.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_ch%0d", i),   64'(rec.rec_ch),   64'(i));
      chk($sformatf("rr_data%0d", i), 64'(rec.rec_data), 64'(32'hA0 + i));
      chk($sformatf("rr_ts%0d", i),   64'(rec.rec_ts),   64'(t0));
      tick();
    end
    rec.rec_ready = 1'b0;
    chk("rr_empty", 64'(rec.rec_valid), 64'd0);

    // overflow: 10 back-to-back ch0 samples, consumer stalled
    t0 = mts;
    for (int k = 0; k < 10; k++) begin
      drive(4'b0001, 32'hD0 + k, 32'h0, 32'h0, 32'h0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("ovf_level", 64'(o_level),       64'd4);
    chk("ovf_drop",  64'(o_drop_cnt),    64'd5);
    chk("ovf_valid", 64'(rec.rec_valid), 64'd1);
    rec.rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovf_valid%0d", i), 64'(rec.rec_valid), 64'd1);
      chk($sformatf("ovf_data%0d", i),  64'(rec.rec_data),  64'(32'hD0 + i));
      chk($sformatf("ovf_ts%0d", i),    64'(rec.rec_ts),    64'(t0 + i));
      tick();
    end
    rec.rec_ready = 1'b0;
    chk("ovf_empty", 64'(rec.rec_valid), 64'd0);
    chk("ovf_level0", 64'(o_level),      64'd0);

    // clear collides with a ch1 sample, 3 records queued
    drive(4'b0111, 32'hC0, 32'hC1, 32'hC2, 32'h0);
    tick();
    idle();
    tick();
    tick();
    tick();
    chk("clr_pre_level", 64'(o_level), 64'd3);
    i_clear = 1'b1;
    drive(4'b0010, 32'h0, 32'hBB, 32'h0, 32'h0);
    tick();
    i_clear = 1'b0;
    idle();
    chk("clr_level", 64'(o_level),       64'd0);
    chk("clr_valid", 64'(rec.rec_valid), 64'd0);
    chk("clr_drop",  64'(o_drop_cnt),    64'd0);
    tick();
    tick();
    tick();
    chk("clr_no_ch1", 64'(rec.rec_valid), 64'd0);
    t0 = mts;
    drive(4'b1000, 32'h0, 32'h0, 32'h0, 32'hCC);
    tick();
    idle();
    tick();
    chk("clr_ts_ch",   64'(rec.rec_ch),   64'd3);
    chk("clr_ts_data", 64'(rec.rec_data), 64'hCC);
    chk("clr_ts",      64'(rec.rec_ts),   64'(t0));
    rec.rec_ready = 1'b1;
    tick();
    rec.rec_ready = 1'b0;

    // asynchronous reset with records queued
    drive(4'b0011, 32'hE0, 32'hE1, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    chk("ar_pre_level", 64'(o_level), 64'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("ar_valid", 64'(rec.rec_valid), 64'd0);
    chk("ar_level", 64'(o_level),       64'd0);
    chk("ar_data",  64'(rec.rec_data),  64'd0);
    chk("ar_ts",    64'(rec.rec_ts),    64'd0);
    chk("ar_ch",    64'(rec.rec_ch),    64'd0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    drive(4'b0101, 32'hF0, 32'h0, 32'hF2, 32'h0);
    tick();
    idle();
    tick();
    chk("ar_first_ch",   64'(rec.rec_ch),   64'd0);
    chk("ar_first_data", 64'(rec.rec_data), 64'hF0);
    chk("ar_first_ts",   64'(rec.rec_ts),   64'd0);
    rec.rec_ready = 1'b1;
    tick();
    chk("ar_second_ch", 64'(rec.rec_ch), 64'd2);
    chk("ar_second_ts", 64'(rec.rec_ts), 64'd0);
    tick();
    rec.rec_ready = 1'b0;

    // repeated values on ch0
    fval = '{32'd5, 32'd5, 32'd7, 32'd7};
`ifdef PROBE_TRACE_FILTER_EN
    nf   = 2;
    fexp = '{32'd5, 32'd7, 32'd0, 32'd0};
`else
    nf   = 4;
    fexp = '{32'd5, 32'd5, 32'd7, 32'd7};
`endif
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, fval[k], 32'h0, 32'h0, 32'h0);
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    chk("flt_level", 64'(o_level), 64'(nf));
    rec.rec_ready = 1'b1;
    for (int i = 0; i < nf; i++) begin
      chk($sformatf("flt_data%0d", i), 64'(rec.rec_data), 64'(fexp[i]));
      tick();
    end
    rec.rec_ready = 1'b0;
    chk("flt_empty", 64'(rec.rec_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_probe_tracer.md
# stage_probe_tracer

Parametrised, synthesizable successor to the core-stage signal probe. Instead of copying fixed stage0/1/2 nets into an interface every cycle, it captures up to NUM_CH independent valid-qualified probe channels (e.g. PC update, decoded instruction, epoch redirect) into time-stamped records. Records go into a FIFO that a checker or a trace dumper drains through a valid/ready handshake. It sits beside the core inside the SoC testbench and in emulation builds.

## Interface
- NUM_CH, 4, number of probe channels (1..16)
- DATA_W, 64, payload width per channel
- DEPTH, 16, record FIFO depth (power of two, >=2)
- TS_W, 32, timestamp width
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- i_en  in  1  capture enable; 0 ignores all i_ch_valid
- i_clear  in  1  synchronous clear of skids, FIFO and drop counter
- i_ch_valid  in  NUM_CH  per-channel sample strobe
- i_ch_data  in  NUM_CH*DATA_W  channel c payload at bits [c*DATA_W +: DATA_W]
- o_rec_valid  out  1  record available
- i_rec_ready  in  1  consumer accepts record
- o_rec_ch  out  $clog2(NUM_CH) (min 1)  channel index of record
- o_rec_data  out  DATA_W  record payload
- o_rec_ts  out  TS_W  timestamp of capture
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy
- o_drop_cnt  out  16  dropped samples, saturating

## Operation
- Timestamp counter: increments every cycle from 0 after reset and wraps modulo 2^TS_W. i_clear does not affect it.
- Per-channel skid: a one-entry register holding {data, ts}. In a cycle with i_en=1 and i_ch_valid[c]=1:
  - skid c empty, or being drained this cycle: load skid c.
  - skid c occupied and not drained: drop the sample and increment o_drop_cnt (saturates at 0xFFFF). Multiple drops in one cycle add their count, still saturating.
- Arbiter: round-robin over occupied skids. Search starts at the channel after the last grant; after reset the last grant is NUM_CH-1, so channel 0 has priority. One grant per cycle, issued only when the FIFO is not full (registered full flag). The granted skid is written to the FIFO as {c, data, ts} and emptied.
- FIFO: show-ahead. o_rec_valid=!empty and o_rec_* reflect the head entry. A pop occurs when o_rec_valid && i_rec_ready. Push and pop in the same cycle leave o_level unchanged. A push is never attempted when full, even if a pop happens that cycle.
- i_clear: empties all skids and the FIFO and zeroes o_drop_cnt. It takes priority over any same-cycle capture, grant or pop; that cycle's inputs are discarded.
- Reset: all skids empty, FIFO empty, last grant = NUM_CH-1, timestamp 0. Outputs: o_rec_valid=0, o_rec_ch=0, o_rec_data=0, o_rec_ts=0, o_level=0, o_drop_cnt=0. Reset asserted mid-operation discards everything immediately (asynchronous).

## Timing
- Capture-to-output latency with an idle FIFO and no contention:
  - sample in cycle N → skid at edge N/N+1 → FIFO write at edge N+1/N+2 → o_rec_valid=1 in cycle N+2.
- Recorded ts equals the timestamp value in cycle N (the sampling cycle), not the write cycle.
- Sustained throughput: one record per cycle into the FIFO. NUM_CH channels all valid every cycle therefore drop NUM_CH-1 samples per cycle in steady state.
- o_rec_* stay stable while o_rec_valid=1 and i_rec_ready=0.
- o_level updates one cycle after the push or pop.

## Configuration
- PROBE_TRACE_FILTER_EN defined: each channel keeps a last-captured-data register, reset to 0 and cleared by i_clear. A valid sample whose data equals that register is neither captured nor counted as a drop. This suppresses repeated identical probe values such as a stalled PC.
- Not defined: every enabled valid sample is captured or dropped as described above; no last-data registers are built.

## Test plan
- Single sample: NUM_CH=4, ch2 valid, data 0x8000_0000 at ts 10 → cycle 12 record {ch=2, data=0x8000_0000, ts=10}, o_level=1; pop → o_level=0, o_rec_valid=0.
- Round-robin: all 4 channels valid once in the same cycle (data 0xA0..0xA3) → records emerge in order ch0, ch1, ch2, ch3, all with the same ts, o_drop_cnt=0.
- Overflow: DEPTH=4, i_rec_ready=0, ch0 valid for 10 consecutive cycles → o_level saturates at 4, skid holds the 5th sample, o_drop_cnt=5; i_rec_ready=1 drains 5 records in order.
- Clear collision: i_clear asserted in the same cycle as ch1 valid with 3 records queued → next cycle o_level=0, o_rec_valid=0, o_drop_cnt=0, the ch1 sample is never output, ts keeps counting.
- Async reset mid-stream: RST_N low between clock edges while records are queued → outputs zero immediately. After release, ts restarts at 0 and arbitration starts at ch0.
- Filter (with PROBE_TRACE_FILTER_EN): ch0 values 5, 5, 7, 7 → exactly two records, data 5 and 7; without the macro → four records.
